axis_y_downsizer: RTL and testbench
===================================

AXIS_Y_DOWNSIZER -- requirements
Module: axis_y_downsizer

Interface
REQ-001 The block SHALL have parameter R, default 8: number of array output lanes per input beat.
REQ-002 The block SHALL have parameter WY, default 32: bits per output lane.
REQ-003 The block SHALL have parameter AXI_WIDTH, default 128: output stream width in bits. Derived values: L = AXI_WIDTH/WY lanes per subword, N = R/L subwords per input beat.
REQ-004 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rstn  in  1  synchronous active-low reset.
REQ-007 s_axis_tdata  in  R*WY  array output row; lane i occupies bits [i*WY +: WY].
REQ-008 s_axis_tkeep  in  R  per-lane valid.
REQ-009 s_axis_tlast, s_axis_tvalid  in  1 each; s_axis_tready  out  1.
REQ-010 m_axis_tdata  out  AXI_WIDTH  data to the s2mm DMA.
REQ-011 m_axis_tkeep  out  AXI_WIDTH/8  byte keep.
REQ-012 m_axis_tlast, m_axis_tvalid  out  1 each; m_axis_tready  in  1.
REQ-013 byte_count  out  32  bytes emitted in the current or most recent packet.
REQ-014 done  out  1  one-cycle pulse after each packet end.
REQ-015 err_keep  out  1  sticky tkeep-protocol violation flag.

Function
REQ-016 Elaboration SHALL fail if AXI_WIDTH%WY!=0, R%L!=0 or WY%8!=0.
REQ-017 The block SHALL use two states: EMPTY (no beat held) and SEND (beat held, subword index k in 0..last).
REQ-018 s_axis_tready SHALL be 1 when state is EMPTY, or when state is SEND and the subword k==last completes its handshake in this cycle (zero-bubble, combinational path from m_axis_tready).
REQ-019 On input handshake the beat SHALL be captured, k set to 0 and state set to SEND; m_axis_tvalid SHALL rise the following cycle (latency 1).
REQ-020 m_axis_tdata SHALL equal held lanes [k*L +: L]; each m_axis_tkeep byte SHALL equal the held keep bit of its lane.
REQ-021 All m_axis outputs SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 For a non-tlast beat, last SHALL be N-1.
REQ-023 For a tlast beat, last SHALL be max(ceil(popcount(tkeep)/L),1)-1, and m_axis_tlast SHALL be 1 only on subword last.
REQ-024 Non-tlast beats with tkeep not all ones SHALL set err_keep; the data SHALL pass with the given keep and N subwords.
REQ-025 tkeep that is non-contiguous from lane 0 SHALL set err_keep.
REQ-026 tkeep=0 on a tlast beat SHALL set err_keep; one subword SHALL be emitted with keep 0 and tlast 1.
REQ-027 byte_count SHALL add the set-byte count of m_axis_tkeep on every output handshake.
REQ-028 The first handshake after a packet end SHALL restart byte_count from that beat's bytes.
REQ-029 done SHALL be 1 for exactly one cycle, the cycle after the tlast handshake, with byte_count then holding the packet total.
REQ-030 In SEND, if the last subword completes with s_axis_tvalid=0, the next state SHALL be EMPTY.
REQ-031 In SEND, if the last subword completes with s_axis_tvalid=1, the new beat SHALL be loaded with no idle cycle.

Reset
REQ-032 While rstn=0: m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0, done=0, byte_count=0, err_keep=0, state=EMPTY, k=0.
REQ-033 Reset asserted mid-packet SHALL discard the held beat; no partial output SHALL follow reset release.
REQ-034 s_axis_tready SHALL be 1 on the first cycle after rstn rises.

Structure
REQ-035 Shared package axis_y_pkg SHALL hold the derived constants L and N, the state enum and the width-check function.
REQ-036 Sub-module lane_keep_count SHALL compute popcount and the contiguity check of an R-bit keep.
REQ-037 Target size is 150-300 lines of RTL; outputs SHALL be registered except s_axis_tready.

Verification
REQ-038 One beat, lanes 0..7 = 1..8, tkeep=FF, tlast=1, m_axis_tready=1 -> two beats {4,3,2,1},{8,7,6,5}; tlast on beat 2; byte_count=32; done pulses once.
REQ-039 Four back-to-back full beats, m_axis_tready=1 -> 8 consecutive output beats, no bubbles; s_axis_tready low on alternate cycles.
REQ-040 tlast beat tkeep=07 -> one beat, m_axis_tkeep=0x0FFF, tlast=1, byte_count=12, err_keep=0.
REQ-041 tkeep=05 on tlast, then tkeep=0F on non-tlast -> err_keep=1 after the first and stays 1.
REQ-042 Random m_axis_tready (50%), 100 packets -> data stable under stall, every byte_count matches the scoreboard.
REQ-043 rstn=0 for 2 cycles after the first subword of a 2-subword beat -> no output until a new beat arrives; byte_count=0.

Source files
------------

// File: rtl/axis_y_pkg.sv
// rtl/axis_y_pkg.sv - shared state type and width helpers for the lane-array downsizer
package axis_y_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    // Lanes carried per output subword.
    function automatic int calc_l(input int axi_width, input int wy);
        return (wy > 0) ? axi_width / wy : 0;
    endfunction

    // Subwords needed to drain one full input beat.
    function automatic int calc_n(input int r, input int axi_width, input int wy);
        int l;
        l = calc_l(axi_width, wy);
        return (l > 0) ? r / l : 0;
    endfunction

    function automatic bit widths_ok(input int r, input int wy, input int axi_width);
        int l;
        if (wy <= 0 || (wy % 8) != 0 || axi_width < wy || (axi_width % wy) != 0)
            return 1'b0;
        l = axi_width / wy;
        return (r >= l) && ((r % l) == 0);
    endfunction

endpackage

// File: rtl/lane_keep_count.sv
// rtl/lane_keep_count.sv - popcount and lane-0 prefix check of a per-lane keep vector
module lane_keep_count #(
    parameter int R  = 8,
    parameter int CW = $clog2(R + 1)
) (
    input  logic [R-1:0]  keep,
    output logic [CW-1:0] count,
    output logic          contig
);

    localparam logic [R-1:0] ONE = {{(R-1){1'b0}}, 1'b1};

    always_comb begin
        count = '0;
        for (int i = 0; i < R; i++)
            count = count + CW'(keep[i]);
    end

    // A prefix mask 0..01..1 has no bit in common with itself plus one.
    assign contig = ((keep & (keep + ONE)) == '0);

endmodule

// File: rtl/axis_y_downsizer.sv
// rtl/axis_y_downsizer.sv - splits an R-lane array row into AXI_WIDTH subwords for the s2mm DMA
module axis_y_downsizer
    import axis_y_pkg::*;
#(
    parameter int R         = 8,
    parameter int WY        = 32,
    parameter int AXI_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [R*WY-1:0]        s_axis_tdata,
    input  logic [R-1:0]           s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [AXI_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [31:0]            byte_count,
    output logic                   done,
    output logic                   err_keep
);

    localparam int L   = calc_l(AXI_WIDTH, WY);
    localparam int N   = calc_n(R, AXI_WIDTH, WY);
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(R + 1);
    localparam int BPL = WY / 8;
    localparam int KB  = AXI_WIDTH / 8;

    generate
        if (!widths_ok(R, WY, AXI_WIDTH)) begin : g_bad_widths
            $error("axis_y_downsizer: WY must be a byte multiple dividing AXI_WIDTH, and R a multiple of AXI_WIDTH/WY");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, last_q, in_last, j;
    logic [R*WY-1:0] data_q, src_data;
    logic [R-1:0]    keep_q, src_keep;
    logic            tlast_q, src_tlast;
    logic [KW-1:0]   src_last;
    logic            restart_q;
    logic            load, advance;
    logic            m_hs, s_hs, at_last, in_bad;
    logic [CW-1:0]   in_cnt;
    logic            in_contig;
    logic [AXI_WIDTH-1:0] sub_data;
    logic [KB-1:0]   sub_keep;
    logic            sub_tlast;
    logic [31:0]     out_bytes;
    int              subs;

    lane_keep_count #(.R(R), .CW(CW)) u_keep_count (
        .keep   (s_axis_tkeep),
        .count  (in_cnt),
        .contig (in_contig)
    );

    assign m_hs    = m_axis_tvalid & m_axis_tready;
    assign at_last = (k_q == last_q);
    // Zero-bubble: the last subword's handshake frees the holding register this same cycle.
    assign s_axis_tready = rstn & ((state_q == ST_EMPTY) | ((state_q == ST_SEND) & m_hs & at_last));
    assign s_hs    = s_axis_tvalid & s_axis_tready;
    assign in_bad  = (~s_axis_tlast & ~(&s_axis_tkeep)) | ~in_contig |
                     (s_axis_tlast & (s_axis_tkeep == '0));

    always_comb begin
        subs = (int'(in_cnt) + L - 1) / L;
        if (subs < 1)
            subs = 1;
        in_last = s_axis_tlast ? KW'(subs - 1) : KW'(N - 1);
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (s_hs) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                end
            end
            ST_SEND: begin
                if (m_hs) begin
                    if (at_last) begin
                        if (s_hs)
                            load = 1'b1;
                        else
                            state_d = ST_EMPTY;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Next subword comes either from the beat being accepted or from the held beat.
    always_comb begin
        src_data  = load ? s_axis_tdata : data_q;
        src_keep  = load ? s_axis_tkeep : keep_q;
        src_tlast = load ? s_axis_tlast : tlast_q;
        src_last  = load ? in_last      : last_q;
        j         = advance ? (k_q + KW'(1)) : '0;
        sub_data  = src_data[int'(j)*AXI_WIDTH +: AXI_WIDTH];
        sub_keep  = '0;
        for (int b = 0; b < KB; b++)
            sub_keep[b] = src_keep[int'(j)*L + b/BPL];
        sub_tlast = src_tlast & (j == src_last);
    end

    always_comb begin
        out_bytes = '0;
        for (int b = 0; b < KB; b++)
            out_bytes = out_bytes + 32'(m_axis_tkeep[b]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_EMPTY;
            k_q           <= '0;
            last_q        <= '0;
            data_q        <= '0;
            keep_q        <= '0;
            tlast_q       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            byte_count    <= '0;
            done          <= 1'b0;
            err_keep      <= 1'b0;
            restart_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            m_axis_tvalid <= (state_d == ST_SEND);
            done          <= m_hs & m_axis_tlast;
            if (load) begin
                data_q  <= s_axis_tdata;
                keep_q  <= s_axis_tkeep;
                tlast_q <= s_axis_tlast;
                last_q  <= in_last;
                k_q     <= '0;
            end else if (advance) begin
                k_q <= k_q + KW'(1);
            end
            if (load || advance) begin
                m_axis_tdata <= sub_data;
                m_axis_tkeep <= sub_keep;
                m_axis_tlast <= sub_tlast;
            end
            if (s_hs && in_bad)
                err_keep <= 1'b1;
            if (m_hs) begin
                byte_count <= restart_q ? out_bytes : byte_count + out_bytes;
                restart_q  <= m_axis_tlast;
            end
        end
    end

endmodule

// File: tb/tb_axis_y_downsizer.sv
// tb/tb_axis_y_downsizer.sv - directed bench for axis_y_downsizer
module tb_axis_y_downsizer;

    localparam int R  = 8;
    localparam int WY = 32;
    localparam int AW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [R*WY-1:0] s_axis_tdata;
    logic [R-1:0]    s_axis_tkeep;
    logic            s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [AW-1:0]   m_axis_tdata;
    logic [AW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [31:0]     byte_count;
    logic            done, err_keep;

    axis_y_downsizer #(.R(R), .WY(WY), .AXI_WIDTH(AW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .byte_count    (byte_count),
        .done          (done),
        .err_keep      (err_keep)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    logic [AW-1:0]   o_data[$];
    logic [AW/8-1:0] o_keep[$];
    bit              o_last[$];
    int              o_cyc[$];
    int              d_bc[$];
    int              stall_viol = 0;
    bit              prev_stall = 1'b0;
    logic [AW-1:0]   prev_d;
    logic [AW/8-1:0] prev_k;
    logic            prev_l;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: records handshakes and done pulses, flags any change while stalled.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d ||
                               m_axis_tkeep !== prev_k || m_axis_tlast !== prev_l))
                stall_viol++;
            if (m_axis_tvalid && m_axis_tready) begin
                o_data.push_back(m_axis_tdata);
                o_keep.push_back(m_axis_tkeep);
                o_last.push_back(m_axis_tlast);
                o_cyc.push_back(cyc);
            end
            if (done)
                d_bc.push_back(int'(byte_count));
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_k = m_axis_tkeep;
            prev_l = m_axis_tlast;
        end
    end

    task automatic clear_mon();
        o_data.delete(); o_keep.delete(); o_last.delete(); o_cyc.delete(); d_bc.delete();
        stall_viol = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rstn = 1'b0;
        s_axis_tvalid = 1'b0;
        wait_cycles(n);
        rstn = 1'b1;
    endtask

    task automatic send_beat(input logic [R*WY-1:0] d, input logic [R-1:0] k,
                             input logic l, output int waits);
        bit hs;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        waits = 0;
        hs = 1'b0;
        while (!hs && waits < 300) begin
            @(negedge clk);
            waits++;
            hs = s_axis_tready;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            n_checks++;
            $display("FAIL send_beat timeout: s_axis_tready never high in %0d cycles", waits);
        end
    endtask

    function automatic logic [R*WY-1:0] ramp_row(input int base);
        logic [R*WY-1:0] d;
        for (int i = 0; i < R; i++)
            d[i*WY +: WY] = WY'(base + i);
        return d;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", m_axis_tlast); else n_pass++;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL reset_s_tready got %b want 0", s_axis_tready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (byte_count !== 32'd0) $display("FAIL reset_byte_count got %0d want 0", byte_count); else n_pass++;
        n_checks++; if (err_keep !== 1'b0) $display("FAIL reset_err_keep got %b want 0", err_keep); else n_pass++;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL release_s_tready got %b want 1", s_axis_tready); else n_pass++;
        wait_cycles(1);
    endtask

    task automatic test_single_packet();
        int w;
        clear_mon();
        m_axis_tready = 1'b1;
        send_beat(ramp_row(1), 8'hFF, 1'b1, w);
        s_axis_tvalid = 1'b0;
        wait_cycles(6);
        n_checks++; if (o_data.size() != 2) $display("FAIL single_beats got %0d want 2", o_data.size()); else n_pass++;
        if (o_data.size() == 2) begin
            n_checks++; if (o_data[0] !== {32'd4, 32'd3, 32'd2, 32'd1} || o_last[0] !== 1'b0 || o_keep[0] !== 16'hFFFF)
                $display("FAIL single_beat0 got %h/%h/%b want 00000004000000030000000200000001/ffff/0", o_data[0], o_keep[0], o_last[0]); else n_pass++;
            n_checks++; if (o_data[1] !== {32'd8, 32'd7, 32'd6, 32'd5} || o_last[1] !== 1'b1 || o_keep[1] !== 16'hFFFF)
                $display("FAIL single_beat1 got %h/%h/%b want 00000008000000070000000600000005/ffff/1", o_data[1], o_keep[1], o_last[1]); else n_pass++;
        end
        n_checks++; if (d_bc.size() != 1) $display("FAIL single_done_pulses got %0d want 1", d_bc.size()); else n_pass++;
        if (d_bc.size() == 1) begin
            n_checks++; if (d_bc[0] != 32) $display("FAIL single_done_count got %0d want 32", d_bc[0]); else n_pass++;
        end
        n_checks++; if (byte_count !== 32'd32) $display("FAIL single_byte_count got %0d want 32", byte_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w[4];
        logic [R*WY-1:0] d[4];
        int gaps, bad;
        clear_mon();
        m_axis_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            d[b] = ramp_row(256 * (b + 1));
            send_beat(d[b], 8'hFF, 1'(b == 3), w[b]);
        end
        s_axis_tvalid = 1'b0;
        wait_cycles(8);
        n_checks++; if (o_data.size() != 8) $display("FAIL b2b_beats got %0d want 8", o_data.size()); else n_pass++;
        if (o_data.size() == 8) begin
            gaps = 0; bad = 0;
            for (int i = 0; i < 8; i++) begin
                if (o_cyc[i] != o_cyc[0] + i) gaps++;
                if (o_data[i] !== d[i/2][(i%2)*AW +: AW] || o_last[i] !== 1'(i == 7)) bad++;
            end
            n_checks++; if (gaps != 0) $display("FAIL b2b_bubbles got %0d want 0", gaps); else n_pass++;
            n_checks++; if (bad != 0) $display("FAIL b2b_data got %0d bad beats want 0", bad); else n_pass++;
        end
        n_checks++; if (w[0] != 1 || w[1] != 2 || w[2] != 2 || w[3] != 2)
            $display("FAIL b2b_s_tready_waits got %0d,%0d,%0d,%0d want 1,2,2,2", w[0], w[1], w[2], w[3]); else n_pass++;
        n_checks++; if (d_bc.size() != 1 || d_bc[0] != 128) $display("FAIL b2b_byte_count got %0d want 128", byte_count); else n_pass++;
    endtask

    task automatic test_partial_keep();
        int w;
        clear_mon();
        send_beat(ramp_row(1), 8'h07, 1'b1, w);
        s_axis_tvalid = 1'b0;
        wait_cycles(5);
        n_checks++; if (o_data.size() != 1) $display("FAIL partial_beats got %0d want 1", o_data.size()); else n_pass++;
        if (o_data.size() == 1) begin
            n_checks++; if (o_keep[0] !== 16'h0FFF || o_last[0] !== 1'b1 || o_data[0] !== {32'd4, 32'd3, 32'd2, 32'd1})
                $display("FAIL partial_beat got %h/%h/%b want 00000004000000030000000200000001/0fff/1", o_data[0], o_keep[0], o_last[0]); else n_pass++;
        end
        n_checks++; if (byte_count !== 32'd12) $display("FAIL partial_byte_count got %0d want 12", byte_count); else n_pass++;
        n_checks++; if (err_keep !== 1'b0) $display("FAIL partial_err_keep got %b want 0", err_keep); else n_pass++;
    endtask

    task automatic test_err_keep();
        int w;
        clear_mon();
        send_beat(ramp_row(1), 8'h05, 1'b1, w);
        s_axis_tvalid = 1'b0;
        wait_cycles(4);
        n_checks++; if (err_keep !== 1'b1) $display("FAIL err_after_05 got %b want 1", err_keep); else n_pass++;
        send_beat(ramp_row(9), 8'h0F, 1'b0, w);
        s_axis_tvalid = 1'b0;
        wait_cycles(5);
        n_checks++; if (err_keep !== 1'b1) $display("FAIL err_sticky got %b want 1", err_keep); else n_pass++;
        n_checks++; if (o_keep.size() != 3) $display("FAIL err_beats got %0d want 3", o_keep.size()); else n_pass++;
        if (o_keep.size() == 3) begin
            n_checks++; if (o_keep[0] !== 16'h0F0F || o_keep[1] !== 16'hFFFF || o_keep[2] !== 16'h0000)
                $display("FAIL err_keeps got %h,%h,%h want 0f0f,ffff,0000", o_keep[0], o_keep[1], o_keep[2]); else n_pass++;
        end
        apply_reset(2);
        wait_cycles(1);
        n_checks++; if (err_keep !== 1'b0) $display("FAIL err_cleared_by_reset got %b want 0", err_keep); else n_pass++;
    endtask

    task automatic test_keep_zero();
        int w;
        clear_mon();
        send_beat(ramp_row(1), 8'h00, 1'b1, w);
        s_axis_tvalid = 1'b0;
        wait_cycles(5);
        n_checks++; if (o_keep.size() != 1) $display("FAIL keep0_beats got %0d want 1", o_keep.size()); else n_pass++;
        if (o_keep.size() == 1) begin
            n_checks++; if (o_keep[0] !== 16'h0000 || o_last[0] !== 1'b1)
                $display("FAIL keep0_beat got %h/%b want 0000/1", o_keep[0], o_last[0]); else n_pass++;
        end
        n_checks++; if (err_keep !== 1'b1) $display("FAIL keep0_err got %b want 1", err_keep); else n_pass++;
        n_checks++; if (d_bc.size() != 1 || d_bc[0] != 0) $display("FAIL keep0_done_count got %0d want 0", byte_count); else n_pass++;
        apply_reset(2);
    endtask

    task automatic test_random_stall();
        logic [AW-1:0]   e_data[$];
        logic [AW/8-1:0] e_keep[$];
        bit              e_last[$];
        int              e_bc[$];
        logic [R*WY-1:0] d;
        logic [R-1:0]    kp;
        logic [AW/8-1:0] ek;
        int nb, cnt, subs, bytes, w, t, bad;
        bit lst;
        clear_mon();
        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            nb = $urandom_range(1, 3);
            bytes = 0;
            for (int b = 0; b < nb; b++) begin
                lst = (b == nb - 1);
                cnt = lst ? $urandom_range(1, 8) : 8;
                kp = 8'((1 << cnt) - 1);
                for (int i = 0; i < R; i++) d[i*WY +: WY] = $urandom;
                subs = lst ? (cnt + 3) / 4 : 2;
                for (int s = 0; s < subs; s++) begin
                    for (int j = 0; j < 4; j++)
                        for (int q = 0; q < 4; q++) begin
                            ek[j*4 + q] = kp[s*4 + j];
                            bytes += int'(kp[s*4 + j]);
                        end
                    e_data.push_back(d[s*AW +: AW]);
                    e_keep.push_back(ek);
                    e_last.push_back(lst && (s == subs - 1));
                end
                send_beat(d, kp, lst, w);
                if ($urandom_range(0, 3) == 0) begin
                    s_axis_tvalid = 1'b0;
                    wait_cycles(1);
                end
            end
            e_bc.push_back(bytes);
        end
        s_axis_tvalid = 1'b0;
        t = 0;
        while ((o_data.size() < e_data.size() || d_bc.size() < e_bc.size()) && t < 4000) begin
            wait_cycles(1);
            t++;
        end
        rand_ready = 1'b0;
        wait_cycles(2);
        m_axis_tready = 1'b1;
        n_checks++; if (o_data.size() != e_data.size()) $display("FAIL rand_beats got %0d want %0d", o_data.size(), e_data.size()); else n_pass++;
        n_checks++; if (d_bc.size() != e_bc.size()) $display("FAIL rand_packets got %0d want %0d", d_bc.size(), e_bc.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++)
            if (o_data[i] !== e_data[i] || o_keep[i] !== e_keep[i] || o_last[i] !== e_last[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL rand_data got %0d bad beats want 0", bad); else n_pass++;
        bad = 0;
        for (int i = 0; i < d_bc.size() && i < e_bc.size(); i++)
            if (d_bc[i] != e_bc[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL rand_byte_count got %0d bad packets want 0", bad); else n_pass++;
        n_checks++; if (stall_viol != 0) $display("FAIL rand_stall_stable got %0d changes want 0", stall_viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w;
        clear_mon();
        m_axis_tready = 1'b0;
        send_beat(ramp_row(32), 8'hFF, 1'b0, w);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        wait_cycles(1);
        m_axis_tready = 1'b0;
        rstn = 1'b0;
        wait_cycles(2);
        rstn = 1'b1;
        m_axis_tready = 1'b1;
        wait_cycles(5);
        n_checks++; if (o_data.size() != 1) $display("FAIL mid_reset_beats got %0d want 1", o_data.size()); else n_pass++;
        n_checks++; if (byte_count !== 32'd0 || m_axis_tvalid !== 1'b0)
            $display("FAIL mid_reset_idle got count %0d valid %b want 0/0", byte_count, m_axis_tvalid); else n_pass++;
        send_beat(ramp_row(64), 8'hFF, 1'b1, w);
        s_axis_tvalid = 1'b0;
        wait_cycles(6);
        n_checks++; if (o_data.size() != 3) $display("FAIL mid_reset_new_beats got %0d want 3", o_data.size()); else n_pass++;
        if (o_data.size() == 3) begin
            n_checks++; if (o_data[1] !== {32'd67, 32'd66, 32'd65, 32'd64})
                $display("FAIL mid_reset_new_data got %h want 00000043000000420000004100000040", o_data[1]); else n_pass++;
        end
        n_checks++; if (d_bc.size() != 1 || byte_count !== 32'd32) $display("FAIL mid_reset_count got %0d want 32", byte_count); else n_pass++;
    endtask

    initial begin
        rstn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_partial_keep();
        test_err_keep();
        test_keep_zero();
        test_random_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
